// File: rtl/mtr_pkg.sv
// Shared types and helpers for the N-channel H-bridge PWM driver.
package mtr_pkg;

    // Default command width; PWM period is 2^PER_W clocks
    localparam int MTR_WIDTH = 11;
    localparam int PER_W     = MTR_WIDTH - 1;

    // Per-channel bridge state
    typedef enum logic [2:0] {COAST, BRAKE, FWD, REV, DEAD} mtr_st_t;

    // |v| clamped to 2^per_w-1. The most negative command therefore maps to
    // full scale instead of wrapping to zero.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int per_w);
        logic [31:0] lim;
        logic [31:0] a;
        lim = (32'd1 << per_w) - 32'd1;
        a   = (v < 0) ? 32'(-v) : 32'(v);
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/mtr_chan.sv
// One motor channel: direction FSM, dead-time timer and registered gate outputs.
module mtr_chan
    import mtr_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int DEAD_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    latch,
    input  logic [WIDTH-2:0]        cnt,
    input  logic signed [WIDTH-1:0] cmd,
    output logic                    fwd,
    output logic                    rev,
    output logic                    dead_act
);
    localparam int PW = WIDTH - 1;

    mtr_st_t          st, st_d, tgt, tgt_d, new_dir;
    logic [PW-1:0]    tmr, tmr_d;
    logic [PW-1:0]    mag_q;

    // Direction requested by the incoming command; only consulted at a latch edge
    always_comb begin
        new_dir = FWD;
        if (cmd == '0)
            new_dir = BRAKE;
        else if (cmd[WIDTH-1])
            new_dir = REV;
    end

    // Next-state: en=0 forces coast; direction reversals detour through DEAD
    always_comb begin
        st_d  = st;
        tgt_d = tgt;
        tmr_d = tmr;
        if (!en) begin
            st_d  = COAST;
            tmr_d = '0;
        end else begin
            case (st)
                DEAD: begin
                    // A new command retargets the dead-time but does not restart it
                    if (latch)
                        tgt_d = new_dir;
                    if (tmr == '0)
                        st_d = latch ? new_dir : tgt;
                    else
                        tmr_d = tmr - PW'(1);
                end
                FWD, REV: begin
                    if (latch) begin
                        if ((st == FWD && new_dir == REV) || (st == REV && new_dir == FWD)) begin
                            st_d  = DEAD;
                            tgt_d = new_dir;
                            tmr_d = PW'(DEAD_CYC - 1);
                        end else begin
                            st_d = new_dir;
                        end
                    end
                end
                default: begin
                    // COAST and BRAKE move directly; the bridge is not cross-driven
                    if (latch)
                        st_d = new_dir;
                end
            endcase
        end
    end

    // State, dead timer and period-aligned magnitude latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= COAST;
            tgt   <= COAST;
            tmr   <= '0;
            mag_q <= '0;
        end else begin
            st  <= st_d;
            tgt <= tgt_d;
            tmr <= tmr_d;
            if (latch)
                mag_q <= PW'(sat_abs(32'(cmd), PW));
        end
    end

    // Gate outputs registered from this cycle's state/cnt; en=0 blanks them immediately
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            fwd      <= 1'b0;
            rev      <= 1'b0;
            dead_act <= 1'b0;
        end else begin
            fwd      <= (st == BRAKE) || (st == FWD && cnt < mag_q);
            rev      <= (st == BRAKE) || (st == REV && cnt < mag_q);
            dead_act <= (st == DEAD);
        end
    end

endmodule

// File: rtl/mtr_drv_nch.sv
// N-channel signed-command H-bridge PWM driver: shared period counter plus per-channel FSMs.
module mtr_drv_nch
    import mtr_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int WIDTH    = MTR_WIDTH,
    parameter int DEAD_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_CH*WIDTH-1:0]  cmd,
    output logic [N_CH-1:0]        fwd,
    output logic [N_CH-1:0]        rev,
    output logic [N_CH-1:0]        dead_act,
    output logic                   per_start
);
    localparam int PW = WIDTH - 1;

    logic [PW-1:0] cnt;
    logic          latch;

    // Commands are sampled on the edge where cnt wraps back to zero
    assign latch = &cnt;

    // Free-running period counter, independent of en
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + PW'(1);
    end

    // Period marker, high in the same cycle as the outputs that reflect cnt==0
    always_ff @(posedge clk) begin
        if (!rst_n)
            per_start <= 1'b0;
        else
            per_start <= (cnt == '0);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mtr_chan #(
            .WIDTH    (WIDTH),
            .DEAD_CYC (DEAD_CYC)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .latch    (latch),
            .cnt      (cnt),
            .cmd      (cmd[i*WIDTH +: WIDTH]),
            .fwd      (fwd[i]),
            .rev      (rev[i]),
            .dead_act (dead_act[i])
        );
    end

endmodule

// File: tb/tb_mtr_drv_nch.sv
// Scoreboard bench for mtr_drv_nch: a period-level reference model predicts every output cycle.
module tb_mtr_drv_nch;
    localparam int N_CH = 2, WIDTH = 11, DEAD_CYC = 8;
    localparam int P = 1 << (WIDTH - 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic [N_CH*WIDTH-1:0] cmd = '0;
    logic [N_CH-1:0]       fwd, rev, dead_act;
    logic                  per_start;

    always #5 clk = ~clk;

    mtr_drv_nch #(.N_CH(N_CH), .WIDTH(WIDTH), .DEAD_CYC(DEAD_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd),
        .fwd(fwd), .rev(rev), .dead_act(dead_act), .per_start(per_start)
    );

    typedef struct packed {
        logic [N_CH-1:0] f;
        logic [N_CH-1:0] r;
        logic [N_CH-1:0] d;
        logic            ps;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: period position, whether the channel is driving, latched
    // sign/magnitude of its command, and remaining dead-time cycles.
    int m_cnt = 0;
    bit m_drv[N_CH];
    int m_sign[N_CH];
    int m_mag[N_CH];
    int m_dead[N_CH];

    always @(posedge clk) begin : model
        exp_t e;
        int   c, ns, nm, pre;
        bit   wrap;
        e = '0;
        if (rst_n) begin
            e.ps = (m_cnt == 0);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (en && m_drv[ch]) begin
                    if (m_dead[ch] > 0)       e.d[ch] = 1'b1;
                    else if (m_sign[ch] == 0) begin e.f[ch] = 1'b1; e.r[ch] = 1'b1; end
                    else if (m_sign[ch] > 0)  e.f[ch] = (m_cnt < m_mag[ch]);
                    else                      e.r[ch] = (m_cnt < m_mag[ch]);
                end
            end
        end
        sbq.push_back(e);
        if (!rst_n) begin
            m_cnt = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_drv[ch] = 0; m_sign[ch] = 0; m_mag[ch] = 0; m_dead[ch] = 0;
            end
        end else begin
            wrap  = (m_cnt == P - 1);
            m_cnt = (m_cnt + 1) % P;
            for (int ch = 0; ch < N_CH; ch++) begin
                c  = $signed(cmd[ch*WIDTH +: WIDTH]);
                ns = (c > 0) ? 1 : ((c < 0) ? -1 : 0);
                nm = (c < 0) ? -c : c;
                if (nm > P - 1) nm = P - 1;
                if (!en) begin
                    m_drv[ch]  = 0;
                    m_dead[ch] = 0;
                end else begin
                    pre = m_dead[ch];
                    if (pre > 0) m_dead[ch] = pre - 1;
                    if (wrap && m_drv[ch] && pre == 0 && ns * m_sign[ch] < 0)
                        m_dead[ch] = DEAD_CYC;
                    if (wrap) m_drv[ch] = 1;
                end
                if (wrap) begin
                    m_sign[ch] = ns;
                    m_mag[ch]  = nm;
                end
            end
        end
    end

    // Monitor: every clock presents one output word; compare it with the oldest prediction
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sbq.pop_front();
            if ({fwd, rev, dead_act, per_start} !== {e.f, e.r, e.d, e.ps}) begin
                errors++;
                $display("FAIL outputs t=%0t got f=%b r=%b d=%b ps=%b want f=%b r=%b d=%b ps=%b",
                         $time, fwd, rev, dead_act, per_start, e.f, e.r, e.d, e.ps);
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_cmd(input int ch, input logic [WIDTH-1:0] v);
        cmd[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (m_cnt == v) return;
        end
        check_eq("wait_cnt_timeout", 0, 1);
    endtask

    // Count high cycles of each output over one full period starting at per_start
    task automatic measure(output int f0, output int f1, output int r0, output int r1, output int d0);
        bit found;
        f0 = 0; f1 = 0; r0 = 0; r1 = 0; d0 = 0;
        found = 0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            @(negedge clk);
            found = (per_start === 1'b1);
        end
        if (!found) begin
            check_eq("per_start_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < P; i++) begin
            if (i != 0) @(negedge clk);
            f0 += int'(fwd[0]); f1 += int'(fwd[1]);
            r0 += int'(rev[0]); r1 += int'(rev[1]);
            d0 += int'(dead_act[0]);
        end
    endtask

    initial begin : stim
        int f0, f1, r0, r1, d0;
        logic [WIDTH-1:0] v;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        set_cmd(0, 11'h0FF);
        set_cmd(1, 11'h1FF);

        // Period before the first latch edge stays coasting
        measure(f0, f1, r0, r1, d0);
        check_eq("coast_first_period_fwd0", f0, 0);
        check_eq("coast_first_period_fwd1", f1, 0);

        // Forward duty
        measure(f0, f1, r0, r1, d0);
        check_eq("duty_fwd0_0x0FF", f0, 255);
        check_eq("duty_fwd1_0x1FF", f1, 511);
        check_eq("duty_rev0_zero", r0 + r1, 0);

        // Reversal: ignored until wrap, then dead-time, then reverse PWM
        set_cmd(0, 11'h700);
        measure(f0, f1, r0, r1, d0);
        check_eq("midperiod_cmd_ignored_fwd0", f0, 255);
        measure(f0, f1, r0, r1, d0);
        check_eq("reversal_dead_cycles", d0, DEAD_CYC);
        check_eq("reversal_rev0_after_dead", r0, 256 - DEAD_CYC);
        check_eq("reversal_fwd0_off", f0, 0);
        measure(f0, f1, r0, r1, d0);
        check_eq("duty_rev0_-256", r0, 256);
        check_eq("no_dead_steady_rev", d0, 0);

        // Most negative command saturates
        set_cmd(0, 11'h400);
        measure(f0, f1, r0, r1, d0);
        measure(f0, f1, r0, r1, d0);
        check_eq("duty_rev0_saturated", r0, P - 1);

        // Brake on zero command, entered directly from either direction
        set_cmd(0, 11'h000);
        set_cmd(1, 11'h000);
        measure(f0, f1, r0, r1, d0);
        measure(f0, f1, r0, r1, d0);
        check_eq("brake_fwd0", f0, P);
        check_eq("brake_rev0", r0, P);
        check_eq("brake_fwd1", f1, P);
        check_eq("brake_no_dead", d0, 0);

        // en=0 mid-period, re-enable mid-period: coast until the next latch
        set_cmd(0, 11'h0FF);
        set_cmd(1, 11'h1FF);
        measure(f0, f1, r0, r1, d0);
        wait_cnt(100);
        en = 1'b0;
        wait_cnt(500);
        en = 1'b1;
        measure(f0, f1, r0, r1, d0);
        check_eq("reenable_duty_fwd0", f0, 255);

        // Reset in the middle of dead-time, then mid-period command change
        set_cmd(0, 11'h700);
        wait_cnt(1000);
        wait_cnt(3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cnt(300);
        set_cmd(0, 11'h0FF);
        measure(f0, f1, r0, r1, d0);
        check_eq("post_reset_fwd0", f0, 255);
        check_eq("post_reset_no_dead", d0, 0);

        // Coast then reverse: no dead-time needed
        en = 1'b0;
        set_cmd(0, 11'h700);
        wait_cnt(200);
        en = 1'b1;
        measure(f0, f1, r0, r1, d0);
        check_eq("coast_to_rev_no_dead", d0, 0);
        check_eq("coast_to_rev_duty", r0, 256);

        // Randomised segments with boundary commands mixed in
        for (int k = 0; k < 10; k++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                case ($urandom_range(0, 5))
                    0:       v = 11'h000;
                    1:       v = 11'h400;
                    2:       v = 11'h3FF;
                    3:       v = 11'h001;
                    4:       v = 11'h7FF;
                    default: v = WIDTH'($urandom);
                endcase
                set_cmd(ch, v);
            end
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 1500)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
